// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and APB protection field values.
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS,
      APB_RESP
   } apb_state_t;

   localparam logic [2:0] PROT_PRIVILEGED  = 3'b001;
   localparam logic [2:0] PROT_NONSECURE   = 3'b010;
   localparam logic [2:0] PROT_INSTRUCTION = 3'b100;
   localparam logic [2:0] PROT_DEFAULT     = 3'b000;

endpackage

// File: rtl/apb_master.sv
// Single-channel APB3/APB4 requester: valid/ready command in, setup/access transfer on APB,
// valid/ready response out, with wait-state support and a programmable ACCESS timeout.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned RW      = 32,
   parameter int unsigned TW      = 8,
   parameter int unsigned TIMEOUT = 255,
   parameter logic [2:0]  PROT    = PROT_DEFAULT
) (
   input  logic            apb_pclk,
   input  logic            nreset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [AW-1:0]   req_addr,
   input  logic [RW-1:0]   req_wdata,
   input  logic [RW/8-1:0] req_strb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [RW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            rsp_timeout,
   output logic [AW-1:0]   apb_paddr,
   output logic            apb_psel,
   output logic            apb_penable,
   output logic            apb_pwrite,
   output logic [RW-1:0]   apb_pwdata,
   output logic [RW/8-1:0] apb_pstrb,
   output logic [2:0]      apb_pprot,
   input  logic            apb_pready,
   input  logic [RW-1:0]   apb_prdata,
   input  logic            apb_pslverr
);

   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
   localparam bit            TO_EN    = (TIMEOUT != 0);

   if (64'(TIMEOUT) >= (64'd1 << TW)) begin : g_bad_timeout
      $error("apb_master: TIMEOUT must be less than 2**TW");
   end

   apb_state_t    state;
   logic [TW-1:0] wait_cnt;

   assign apb_pprot = PROT;

   // req_ready is a register so it stays low through reset and rises one cycle after release.
   always_ff @(posedge apb_pclk) begin
      if (!nreset) begin
         state       <= APB_IDLE;
         req_ready   <= 1'b0;
         apb_paddr   <= '0;
         apb_pwrite  <= 1'b0;
         apb_pwdata  <= '0;
         apb_pstrb   <= '0;
         apb_psel    <= 1'b0;
         apb_penable <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            APB_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  apb_paddr  <= req_addr;
                  apb_pwrite <= req_write;
                  apb_pwdata <= req_wdata;
                  apb_pstrb  <= req_write ? req_strb : '0;
                  apb_psel   <= 1'b1;
                  wait_cnt   <= '0;
                  req_ready  <= 1'b0;
                  state      <= APB_SETUP;
               end
            end
            APB_SETUP: begin
               apb_penable <= 1'b1;
               state       <= APB_ACCESS;
            end
            APB_ACCESS: begin
               if (apb_pready) begin
                  rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                  rsp_err     <= apb_pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  apb_psel    <= 1'b0;
                  apb_penable <= 1'b0;
                  state       <= APB_RESP;
               end else if (TO_EN && (wait_cnt == TO_LIMIT)) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  apb_psel    <= 1'b0;
                  apb_penable <= 1'b0;
                  state       <= APB_RESP;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            APB_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= APB_IDLE;
               end
            end
            default: state <= APB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a memory-backed APB slave with controllable wait states and
// error injection drives one instance; a second instance with TIMEOUT=3 sees a stuck slave.
module tb_apb_master;
   import apb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nreset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   logic        t_req_valid, t_req_ready, t_req_write;
   logic [31:0] t_req_addr, t_req_wdata;
   logic [3:0]  t_req_strb;
   logic        t_rsp_valid, t_rsp_err, t_rsp_timeout;
   logic [31:0] t_rsp_rdata;
   logic [31:0] t_paddr, t_pwdata, t_prdata;
   logic        t_psel, t_penable, t_pwrite, t_pready, t_pslverr, t_rsp_ready;
   logic [3:0]  t_pstrb;
   logic [2:0]  t_pprot;

   assign t_pready    = 1'b0;
   assign t_prdata    = 32'hFFFF_FFFF;
   assign t_pslverr   = 1'b0;
   assign t_rsp_ready = 1'b1;

   apb_master #(.AW(32), .RW(32), .TW(8), .TIMEOUT(255), .PROT(PROT_PRIVILEGED | PROT_NONSECURE)) dut (
      .apb_pclk(clk), .nreset(nreset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
      .apb_pwdata(pwdata), .apb_pstrb(pstrb), .apb_pprot(pprot),
      .apb_pready(pready), .apb_prdata(prdata), .apb_pslverr(pslverr)
   );

   apb_master #(.AW(32), .RW(32), .TW(8), .TIMEOUT(3)) dut_to (
      .apb_pclk(clk), .nreset(nreset),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(t_req_write),
      .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_strb(t_req_strb),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_rdata(t_rsp_rdata),
      .rsp_err(t_rsp_err), .rsp_timeout(t_rsp_timeout),
      .apb_paddr(t_paddr), .apb_psel(t_psel), .apb_penable(t_penable), .apb_pwrite(t_pwrite),
      .apb_pwdata(t_pwdata), .apb_pstrb(t_pstrb), .apb_pprot(t_pprot),
      .apb_pready(t_pready), .apb_prdata(t_prdata), .apb_pslverr(t_pslverr)
   );

   // APB register-file slave: 16 words, byte strobes, programmable wait states.
   logic [31:0] mem [16];
   int          acc_cnt;
   int          wait_cycles;
   logic        mem_clr, force_err, force_rd_en;
   logic [31:0] force_rd;

   assign pready  = (acc_cnt >= wait_cycles);
   assign prdata  = force_rd_en ? force_rd : mem[paddr[5:2]];
   assign pslverr = force_err;

   always @(posedge clk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      end else if (psel && penable && pready && pwrite) begin
         for (int b = 0; b < 4; b++)
            if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [16];
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
      req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (req_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int n);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (rsp_valid === 1'b1);
   endtask

   task automatic test_reset();
      nreset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; t_req_valid = 1'b0;
      req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      t_req_write = 1'b0; t_req_addr = '0; t_req_wdata = '0; t_req_strb = '0;
      wait_cycles = 0; force_err = 1'b0; force_rd_en = 1'b0; force_rd = '0; mem_clr = 1'b1;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      checks++;
      if ({req_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000", {req_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout});
      end
      checks++;
      if ({paddr, pwdata, pstrb, pwrite, rsp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: got paddr=%h pwdata=%h pstrb=%h pwrite=%b rdata=%h expected all 0",
                  paddr, pwdata, pstrb, pwrite, rsp_rdata);
      end
      checks++;
      if ({t_req_ready, t_psel, t_penable, t_rsp_valid, t_pwdata, t_pstrb} !== '0) begin
         errors++;
         $display("FAIL reset_to_dut: got ready=%b psel=%b pen=%b rv=%b pwdata=%h pstrb=%h expected 0",
                  t_req_ready, t_psel, t_penable, t_rsp_valid, t_pwdata, t_pstrb);
      end
      checks++;
      if ({pprot, t_pprot} !== 6'b011_000) begin
         errors++;
         $display("FAIL pprot: got %b/%b expected 011/000", pprot, t_pprot);
      end
      nreset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_write_read();
      bit   ok;
      int   n;
      exp_t e;
      sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
      ref_mem[1] = merge(ref_mem[1], 32'hDEAD_BEEF, 4'hF);
      send_req(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL wr_handshake: got %b expected 1", ok); end
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {3'b101, 32'h04, 32'hDEAD_BEEF, 4'hF}) begin
         errors++;
         $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h data=%h strb=%h expected 1 0 1 00000004 deadbeef f",
                  psel, penable, pwrite, paddr, pwdata, pstrb);
      end
      @(posedge clk); #1;
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
         errors++; $display("FAIL wr_access: got sel/en/rv=%b expected 110", {psel, penable, rsp_valid});
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, psel, penable} !== 3'b100) begin
         errors++; $display("FAIL wr_rsp_cycle: got rv/sel/en=%b expected 100", {rsp_valid, psel, penable});
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL wr_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++; $display("FAIL wr_idle: got rv/ready=%b expected 01", {rsp_valid, req_ready});
      end

      sb.push_back('{rdata: ref_mem[1], err: 1'b0, to: 1'b0});
      send_req(1'b0, 32'h04, 32'h5555_5555, 4'hF, ok);
      checks++;
      if ({ok, pwrite, pstrb} !== {1'b1, 1'b0, 4'h0}) begin
         errors++; $display("FAIL rd_setup: got ok=%b pwrite=%b pstrb=%h expected 1 0 0", ok, pwrite, pstrb);
      end
      wait_rsp(ok, n);
      checks++;
      if (ok !== 1'b1 || n != 2) begin
         errors++; $display("FAIL rd_latency: got ok=%b cycles=%0d expected 1 2", ok, n);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL rd_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wait_states();
      bit          ok, stable, last_pready;
      int          n, en_cycles;
      logic [31:0] a0;
      exp_t        e;
      sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
      ref_mem[2] = merge(ref_mem[2], 32'hAABB_CCDD, 4'h5);
      send_req(1'b1, 32'h08, 32'hAABB_CCDD, 4'h5, ok);
      wait_rsp(ok, n);
      e = sb.pop_front();
      checks++;
      if (ok !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++; $display("FAIL strb_wr_rsp: got ok=%b rdata=%h err=%b to=%b expected 1 %h %b %b",
                            ok, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;

      wait_cycles = 5;
      sb.push_back('{rdata: ref_mem[2], err: 1'b0, to: 1'b0});
      send_req(1'b0, 32'h08, 32'h0, 4'h0, ok);
      a0 = paddr; stable = 1'b1; en_cycles = 0; last_pready = 1'b0; n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
         if (penable === 1'b1) begin en_cycles++; last_pready = pready; end
         if (paddr !== a0) stable = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (en_cycles != 6 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL wait_penable: got %0d cycles rv=%b expected 6 1", en_cycles, rsp_valid);
      end
      checks++;
      if (stable !== 1'b1 || a0 !== 32'h08 || last_pready !== 1'b1) begin
         errors++; $display("FAIL wait_addr: got stable=%b addr=%h last_pready=%b expected 1 00000008 1",
                            stable, a0, last_pready);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL wait_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      wait_cycles = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_slverr();
      bit   ok;
      int   n;
      exp_t e;
      force_err = 1'b1; force_rd_en = 1'b1; force_rd = 32'h0000_1234;
      sb.push_back('{rdata: 32'h0000_1234, err: 1'b1, to: 1'b0});
      send_req(1'b0, 32'h0C, 32'h0, 4'h0, ok);
      wait_rsp(ok, n);
      e = sb.pop_front();
      checks++;
      if (ok !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++; $display("FAIL slverr_rsp: got ok=%b rdata=%h err=%b to=%b expected 1 %h %b %b",
                            ok, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;
      force_err = 1'b0; force_rd_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit          ok, ok2;
      int          n, hold_bad;
      logic [33:0] cap;
      exp_t        e;
      rsp_ready = 1'b0;
      sb.push_back('{rdata: ref_mem[1], err: 1'b0, to: 1'b0});
      send_req(1'b0, 32'h04, 32'h0, 4'h0, ok);
      wait_rsp(ok, n);
      cap = {rsp_rdata, rsp_err, rsp_timeout};
      e = sb.pop_front();
      checks++;
      if (ok !== 1'b1 || cap !== {e.rdata, e.err, e.to}) begin
         errors++; $display("FAIL bp_rsp: got ok=%b rsp=%h expected 1 %h", ok, cap, {e.rdata, e.err, e.to});
      end
      sb.push_back('{rdata: ref_mem[2], err: 1'b0, to: 1'b0});
      req_write = 1'b0; req_addr = 32'h08; req_valid = 1'b1;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== cap) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin
         errors++; $display("FAIL bp_hold: got %0d disturbed cycles expected 0", hold_bad);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, psel} !== 3'b100) begin
         errors++; $display("FAIL bp_release: got ready/rv/sel=%b expected 100", {req_ready, rsp_valid, psel});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if ({psel, penable, paddr} !== {2'b10, 32'h08}) begin
         errors++; $display("FAIL bp_accept: got sel=%b en=%b addr=%h expected 1 0 00000008", psel, penable, paddr);
      end
      wait_rsp(ok2, n);
      e = sb.pop_front();
      checks++;
      if (ok2 !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++; $display("FAIL bp_second: got ok=%b rdata=%h err=%b to=%b expected 1 %h %b %b",
                            ok2, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      bit   ok;
      int   n, en_cycles;
      exp_t e;
      sb.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
      t_req_write = 1'b0; t_req_addr = 32'h20; t_req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (t_req_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      t_req_valid = 1'b0;
      en_cycles = 0; n = 0;
      while (t_rsp_valid !== 1'b1 && n < 50) begin
         if (t_penable === 1'b1) en_cycles++;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (ok !== 1'b1 || en_cycles != 4 || t_rsp_valid !== 1'b1) begin
         errors++; $display("FAIL to_access_len: got ok=%b cycles=%0d rv=%b expected 1 4 1", ok, en_cycles, t_rsp_valid);
      end
      checks++;
      if ({t_psel, t_penable, t_pwrite, t_paddr} !== {3'b000, 32'h20}) begin
         errors++; $display("FAIL to_bus: got sel=%b en=%b wr=%b addr=%h expected 0 0 0 00000020",
                            t_psel, t_penable, t_pwrite, t_paddr);
      end
      e = sb.pop_front();
      checks++;
      if ({t_rsp_rdata, t_rsp_err, t_rsp_timeout} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL to_rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                  t_rsp_rdata, t_rsp_err, t_rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen;
      wait_cycles = 5;
      send_req(1'b0, 32'h04, 32'h0, 4'h0, ok);
      @(posedge clk); #1;
      checks++;
      if ({ok, psel, penable} !== 3'b111) begin
         errors++; $display("FAIL rst_mid_access: got ok/sel/en=%b expected 111", {ok, psel, penable});
      end
      nreset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({psel, penable, req_ready, rsp_valid, paddr} !== {4'b0000, 32'h0}) begin
         errors++; $display("FAIL rst_mid_drop: got sel=%b en=%b ready=%b rv=%b addr=%h expected 0 0 0 0 0",
                            psel, penable, req_ready, rsp_valid, paddr);
      end
      nreset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid === 1'b1 || psel === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rst_mid_no_rsp: got %0d active cycles expected 0", seen);
      end
      wait_cycles = 0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_slverr();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
